// File: rtl/conv_pkg.sv
// Shared definitions for the decimal/binary converters.
package conv_pkg;

  localparam int unsigned DIGIT_W            = 4;
  localparam logic [DIGIT_W-1:0] MAX_BCD     = 4'd9;
  // 10^120-1 still fits below 2^400, so 120 digits can never lose precision at W=400.
  localparam int unsigned MAX_DIGITS_DEFAULT = 120;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } conv_state_t;

endpackage

// File: rtl/mul10_add.sv
// Multiplier-free acc*10 + d, widened by four bits so the caller can detect overflow.
module mul10_add #(
  parameter int unsigned W = 400
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   d,
  output logic [W+3:0] sum
);

  logic [W+3:0] acc_ext;

  // acc*10 formed as (acc<<3)+(acc<<1), plus the incoming digit
  always_comb begin
    acc_ext = (W+4)'(acc);
    sum     = (acc_ext << 3) + (acc_ext << 1) + (W+4)'(d);
  end

endmodule

// File: rtl/convert_from_10.sv
// Converts an MS-digit-first BCD stream into an unsigned W-bit binary integer.
module convert_from_10
  import conv_pkg::*;
#(
  parameter int unsigned W          = 400,
  parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEFAULT,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         digit,
  input  logic               digit_valid,
  input  logic               digit_last,
  output logic               digit_ready,
  output logic [W-1:0]       binary,
  output logic               done,
  output logic               busy,
  output logic               overflow,
  output logic               err_digit,
  output logic [CNT_W-1:0]   digit_count
);

  conv_state_t      state;
  logic [W+3:0]     sum;
  logic             accept;
  logic [CNT_W-1:0] count_next;

  mul10_add #(.W(W)) u_mul10_add (
    .acc (binary),
    .d   (digit),
    .sum (sum)
  );

  // Ready only while accumulating; a start in the same cycle takes priority over the digit
  always_comb begin
    digit_ready = (state == ACCUM) && !start;
    accept      = digit_valid && digit_ready;
    count_next  = digit_count + CNT_W'(1);
  end

  // Conversion FSM with registered result and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      binary      <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      err_digit   <= 1'b0;
      digit_count <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= ACCUM;
        binary      <= '0;
        busy        <= 1'b1;
        overflow    <= 1'b0;
        err_digit   <= 1'b0;
        digit_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          ACCUM: begin
            if (accept) begin
              digit_count <= count_next;
              if (digit <= MAX_BCD) begin
                // Keep accumulating on the truncated value; overflow stays sticky
                binary <= sum[W-1:0];
                if (|sum[W+3:W]) begin
                  overflow <= 1'b1;
                end
              end else begin
                err_digit <= 1'b1;
              end
              if (digit_last || (count_next == CNT_W'(MAX_DIGITS))) begin
                state <= FINISH;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
          FINISH: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_convert_from_10.sv
// Directed bench for convert_from_10: a default-width instance and a W=8 instance share stimulus.
module tb_convert_from_10;

  localparam int unsigned WB = 400;
  localparam int unsigned WS = 8;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [3:0]      digit;
  logic            digit_valid;
  logic            digit_last;

  logic            big_ready, big_done, big_busy, big_ovf, big_err;
  logic [WB-1:0]   big_binary;
  logic [7:0]      big_count;

  logic            sm_ready, sm_done, sm_busy, sm_ovf, sm_err;
  logic [WS-1:0]   sm_binary;
  logic [7:0]      sm_count;

  int checks;
  int failures;
  logic [WB-1:0] nines120;

  convert_from_10 u_big (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_last  (digit_last),
    .digit_ready (big_ready),
    .binary      (big_binary),
    .done        (big_done),
    .busy        (big_busy),
    .overflow    (big_ovf),
    .err_digit   (big_err),
    .digit_count (big_count)
  );

  convert_from_10 #(.W(WS)) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_last  (digit_last),
    .digit_ready (sm_ready),
    .binary      (sm_binary),
    .done        (sm_done),
    .busy        (sm_busy),
    .overflow    (sm_ovf),
    .err_digit   (sm_err),
    .digit_count (sm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after start has been sampled.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; presents one digit for one edge and returns at the following negedge.
  task automatic send_digit(input logic [3:0] d, input logic last);
    digit       = d;
    digit_valid = 1'b1;
    digit_last  = last;
    #1;
    chk("ready_before_accept", WB'(big_ready), WB'(1'b1));
    @(posedge clk);
    @(negedge clk);
    digit_valid = 1'b0;
    digit_last  = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    digit       = 4'd0;
    digit_valid = 1'b0;
    digit_last  = 1'b0;

    nines120 = WB'(1);
    for (int i = 0; i < 120; i++) nines120 = nines120 * WB'(10);
    nines120 = nines120 - WB'(1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_binary", big_binary, '0);
    chk("rst_done", WB'(big_done), '0);
    chk("rst_busy", WB'(big_busy), '0);
    chk("rst_ovf", WB'(big_ovf), '0);
    chk("rst_err", WB'(big_err), '0);
    chk("rst_count", WB'(big_count), '0);
    chk("rst_ready", WB'(big_ready), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2,5,5 -> 255 on both widths
    do_start();
    chk("start_busy", WB'(big_busy), WB'(1'b1));
    chk("start_binary", big_binary, '0);
    send_digit(4'd2, 1'b0);
    chk("done_early", WB'(big_done), '0);
    send_digit(4'd5, 1'b0);
    send_digit(4'd5, 1'b1);
    chk("255_done", WB'(big_done), WB'(1'b1));
    chk("255_binary", big_binary, WB'(255));
    chk("255_count", WB'(big_count), WB'(3));
    chk("255_ovf", WB'(big_ovf), '0);
    chk("255_err", WB'(big_err), '0);
    chk("255_busy", WB'(big_busy), '0);
    chk("255_sm_binary", WB'(sm_binary), WB'(8'hFF));
    chk("255_sm_ovf", WB'(sm_ovf), '0);
    @(negedge clk);
    chk("255_done_one_cycle", WB'(big_done), '0);
    chk("idle_ready", WB'(big_ready), '0);
    chk("idle_hold_binary", big_binary, WB'(255));

    // 2,5,6 -> overflows the 8-bit instance to zero
    do_start();
    send_digit(4'd2, 1'b0);
    send_digit(4'd5, 1'b0);
    send_digit(4'd6, 1'b1);
    chk("256_sm_ovf", WB'(sm_ovf), WB'(1'b1));
    chk("256_sm_binary", WB'(sm_binary), '0);
    chk("256_sm_done", WB'(sm_done), WB'(1'b1));
    chk("256_big_binary", big_binary, WB'(256));
    chk("256_big_ovf", WB'(big_ovf), '0);

    // 1, 0xA, 2 -> bad digit flagged, skipped in value, still counted
    do_start();
    chk("restart_clears_ovf", WB'(sm_ovf), '0);
    send_digit(4'd1, 1'b0);
    send_digit(4'hA, 1'b0);
    send_digit(4'd2, 1'b1);
    chk("err_flag", WB'(big_err), WB'(1'b1));
    chk("err_binary", big_binary, WB'(12));
    chk("err_count", WB'(big_count), WB'(3));
    chk("err_done", WB'(big_done), WB'(1'b1));

    // 7,7 then start with a digit presented: digit ignored, conversion restarts
    do_start();
    chk("restart_clears_err", WB'(big_err), '0);
    send_digit(4'd7, 1'b0);
    send_digit(4'd7, 1'b0);
    chk("77_binary", big_binary, WB'(77));
    start       = 1'b1;
    digit       = 4'd3;
    digit_valid = 1'b1;
    #1;
    chk("start_blocks_ready", WB'(big_ready), '0);
    @(negedge clk);
    start       = 1'b0;
    digit_valid = 1'b0;
    chk("restart_binary", big_binary, '0);
    chk("restart_count", WB'(big_count), '0);
    chk("restart_busy", WB'(big_busy), WB'(1'b1));
    send_digit(4'd4, 1'b1);
    chk("4_binary", big_binary, WB'(4));
    chk("4_done", WB'(big_done), WB'(1'b1));

    // 120 nines with no last: forced completion
    do_start();
    for (int i = 0; i < 120; i++) begin
      send_digit(4'd9, 1'b0);
      if (i == 118) begin
        chk("119_not_done", WB'(big_done), '0);
        chk("119_busy", WB'(big_busy), WB'(1'b1));
        chk("119_count", WB'(big_count), WB'(119));
      end
    end
    chk("120_done", WB'(big_done), WB'(1'b1));
    chk("120_count", WB'(big_count), WB'(120));
    chk("120_binary", big_binary, nines120);
    chk("120_ovf", WB'(big_ovf), '0);
    chk("120_busy", WB'(big_busy), '0);

    // Reset in the middle of a conversion
    do_start();
    send_digit(4'd9, 1'b0);
    send_digit(4'd9, 1'b0);
    chk("99_binary", big_binary, WB'(99));
    rst_n = 1'b0;
    #1;
    chk("arst_binary", big_binary, '0);
    chk("arst_busy", WB'(big_busy), '0);
    chk("arst_count", WB'(big_count), '0);
    chk("arst_ovf_err", WB'({big_ovf, big_err}), '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", WB'(big_done), '0);
    end
    rst_n       = 1'b1;
    digit       = 4'd5;
    digit_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", WB'(big_ready), '0);
    chk("post_rst_count", WB'(big_count), '0);
    chk("post_rst_binary", big_binary, '0);
    chk("post_rst_done", WB'(big_done), '0);
    digit_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
